// File: rtl/reg_scoreboard.sv
// reg_scoreboard: tracks in-flight register writers in EX/MEM/WB shadow slots
// and produces the per-register invalid codes used for stalls and forwarding.
//
// Ports:
//   clk, reset                 rising-edge clock, synchronous active-high reset
//   regwrite_cur, dest_id,
//   from_main_mem_id           writer leaving ID this edge (dest, load flag)
//   en_*/flush_*               pipeline register controls per stage
//   register_invalid[NREG]     0 none, 1 stall, 2 fwd EX/MEM, 3 fwd MEM/WB
//   pipeline_empty             no valid writer in any slot
//   writers_inflight           number of valid slots (0..3)
module reg_scoreboard #(
    parameter int NREG         = 8,
    parameter int AW           = 3,
    parameter bit LOAD_FWD_MEM = 1'b1
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          regwrite_cur,
    input  logic [AW-1:0] dest_id,
    input  logic          from_main_mem_id,
    input  logic          en_idex,
    input  logic          flush_idex,
    input  logic          en_exmem,
    input  logic          flush_exmem,
    input  logic          en_memwb,
    input  logic          flush_memwb,
    output logic [2:0]    register_invalid [NREG-1:0],
    output logic          pipeline_empty,
    output logic [1:0]    writers_inflight
);

    typedef struct packed {
        logic          valid;
        logic [AW-1:0] dest;
        logic          is_load;
    } slot_t;

    slot_t ex_s;
    slot_t mem_s;
    slot_t wb_s;

    // Each slot follows its own stage controls; flush beats enable.
    // Only the valid bits need a reset value.
    always_ff @(posedge clk) begin
        if (reset) begin
            ex_s.valid  <= 1'b0;
            mem_s.valid <= 1'b0;
            wb_s.valid  <= 1'b0;
        end else begin
            if (flush_idex) begin
                ex_s.valid <= 1'b0;
            end else if (en_idex) begin
                ex_s.valid   <= regwrite_cur;
                ex_s.dest    <= dest_id;
                ex_s.is_load <= from_main_mem_id;
            end

            if (flush_exmem) begin
                mem_s.valid <= 1'b0;
            end else if (en_exmem) begin
                mem_s <= ex_s;
            end

            if (flush_memwb) begin
                wb_s.valid <= 1'b0;
            end else if (en_memwb) begin
                wb_s <= mem_s;
            end
        end
    end

    // Youngest writer wins. A WB writer never blocks: the register file
    // is write-first, so ID reads the new value in the same cycle.
    always_comb begin
        for (int r = 0; r < NREG; r++) begin
            register_invalid[r] = 3'd0;
            if (ex_s.valid && ex_s.dest == AW'(r)) begin
                register_invalid[r] = ex_s.is_load ? 3'd1 : 3'd2;
            end else if (mem_s.valid && mem_s.dest == AW'(r)) begin
                register_invalid[r] =
                    (mem_s.is_load && !LOAD_FWD_MEM) ? 3'd1 : 3'd3;
            end
        end
    end

    assign pipeline_empty   = !(ex_s.valid | mem_s.valid | wb_s.valid);
    assign writers_inflight = 2'(ex_s.valid) + 2'(mem_s.valid)
                            + 2'(wb_s.valid);

endmodule

// File: tb/tb_reg_scoreboard.sv
// tb_reg_scoreboard: directed tests of reg_scoreboard, with a second
// instance built with LOAD_FWD_MEM=0 for the load-in-MEM stall case.
module tb_reg_scoreboard;

    localparam int NREG = 8;
    localparam int AW   = 3;

    logic          clk = 1'b0;
    logic          reset;
    logic          regwrite_cur;
    logic [AW-1:0] dest_id;
    logic          from_main_mem_id;
    logic          en_idex, flush_idex;
    logic          en_exmem, flush_exmem;
    logic          en_memwb, flush_memwb;

    logic [2:0]    ri  [NREG-1:0];
    logic          empty;
    logic [1:0]    inflight;
    logic [2:0]    ri0 [NREG-1:0];
    logic          empty0;
    logic [1:0]    inflight0;

    int pass_cnt  = 0;
    int total_cnt = 0;

    always #5 clk = ~clk;

    reg_scoreboard #(.NREG(NREG), .AW(AW), .LOAD_FWD_MEM(1'b1)) dut (
        .clk(clk), .reset(reset),
        .regwrite_cur(regwrite_cur), .dest_id(dest_id),
        .from_main_mem_id(from_main_mem_id),
        .en_idex(en_idex), .flush_idex(flush_idex),
        .en_exmem(en_exmem), .flush_exmem(flush_exmem),
        .en_memwb(en_memwb), .flush_memwb(flush_memwb),
        .register_invalid(ri), .pipeline_empty(empty),
        .writers_inflight(inflight)
    );

    reg_scoreboard #(.NREG(NREG), .AW(AW), .LOAD_FWD_MEM(1'b0)) dut0 (
        .clk(clk), .reset(reset),
        .regwrite_cur(regwrite_cur), .dest_id(dest_id),
        .from_main_mem_id(from_main_mem_id),
        .en_idex(en_idex), .flush_idex(flush_idex),
        .en_exmem(en_exmem), .flush_exmem(flush_exmem),
        .en_memwb(en_memwb), .flush_memwb(flush_memwb),
        .register_invalid(ri0), .pipeline_empty(empty0),
        .writers_inflight(inflight0)
    );

    // Advance one edge; inputs change and outputs are sampled 1 after it.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        regwrite_cur     = 1'b0;
        dest_id          = '0;
        from_main_mem_id = 1'b0;
        en_idex  = 1'b1; flush_idex  = 1'b0;
        en_exmem = 1'b1; flush_exmem = 1'b0;
        en_memwb = 1'b1; flush_memwb = 1'b0;
    endtask

    task automatic do_reset();
        idle_inputs();
        reset = 1'b1;
        step();
        reset = 1'b0;
    endtask

    task automatic issue(input logic [AW-1:0] d, input logic ld);
        regwrite_cur     = 1'b1;
        dest_id          = d;
        from_main_mem_id = ld;
        step();
        regwrite_cur     = 1'b0;
        from_main_mem_id = 1'b0;
    endtask

    task automatic test_reset();
        do_reset();
        for (int r = 0; r < NREG; r++) begin
            total_cnt++;
            if (ri[r] !== 3'd0 || ri0[r] !== 3'd0)
                $display("FAIL reset_code[%0d] got %0d/%0d want 0",
                         r, ri[r], ri0[r]);
            else pass_cnt++;
        end
        total_cnt++;
        if (empty !== 1'b1 || inflight !== 2'd0)
            $display("FAIL reset_status empty=%b inflight=%0d want 1/0",
                     empty, inflight);
        else pass_cnt++;
    endtask

    task automatic test_alu_write();
        logic [2:0] exp3 [4];
        logic [1:0] expn [4];
        exp3 = '{3'd2, 3'd3, 3'd0, 3'd0};
        expn = '{2'd1, 2'd1, 2'd1, 2'd0};
        do_reset();
        issue(3'd3, 1'b0);
        for (int c = 0; c < 4; c++) begin
            total_cnt++;
            if (ri[3] !== exp3[c] || inflight !== expn[c])
                $display("FAIL alu_r3 cyc%0d got %0d/%0d want %0d/%0d",
                         c + 2, ri[3], inflight, exp3[c], expn[c]);
            else pass_cnt++;
            for (int r = 0; r < NREG; r++) begin
                if (r != 3) begin
                    total_cnt++;
                    if (ri[r] !== 3'd0)
                        $display("FAIL alu_other[%0d] cyc%0d got %0d want 0",
                                 r, c + 2, ri[r]);
                    else pass_cnt++;
                end
            end
            step();
        end
    endtask

    task automatic test_load();
        logic [2:0] e1 [3];
        logic [2:0] e0 [3];
        e1 = '{3'd1, 3'd3, 3'd0};
        e0 = '{3'd1, 3'd1, 3'd0};
        do_reset();
        issue(3'd5, 1'b1);
        for (int c = 0; c < 3; c++) begin
            total_cnt++;
            if (ri[5] !== e1[c])
                $display("FAIL load_fwd cyc%0d got %0d want %0d",
                         c + 2, ri[5], e1[c]);
            else pass_cnt++;
            total_cnt++;
            if (ri0[5] !== e0[c])
                $display("FAIL load_nofwd cyc%0d got %0d want %0d",
                         c + 2, ri0[5], e0[c]);
            else pass_cnt++;
            step();
        end
    endtask

    task automatic test_back_to_back();
        do_reset();
        issue(3'd2, 1'b0);
        issue(3'd2, 1'b1);
        total_cnt++;
        if (ri[2] !== 3'd1)
            $display("FAIL b2b_cyc3 got %0d want 1", ri[2]);
        else pass_cnt++;
        step();
        total_cnt++;
        if (ri[2] !== 3'd3 || ri0[2] !== 3'd1)
            $display("FAIL b2b_cyc4 got %0d/%0d want 3/1", ri[2], ri0[2]);
        else pass_cnt++;
    endtask

    task automatic test_stall();
        do_reset();
        issue(3'd4, 1'b1);
        regwrite_cur = 1'b1;
        dest_id      = 3'd4;
        flush_idex   = 1'b1;
        step();
        idle_inputs();
        total_cnt++;
        if (ri[4] !== 3'd3 || inflight !== 2'd1)
            $display("FAIL stall got code=%0d inflight=%0d want 3/1",
                     ri[4], inflight);
        else pass_cnt++;
    endtask

    task automatic test_hold();
        do_reset();
        issue(3'd6, 1'b0);
        en_idex = 1'b0; en_exmem = 1'b0; en_memwb = 1'b0;
        regwrite_cur = 1'b1;
        dest_id      = 3'd1;
        step();
        step();
        idle_inputs();
        total_cnt++;
        if (ri[6] !== 3'd2 || ri[1] !== 3'd0 || inflight !== 2'd1)
            $display("FAIL hold got r6=%0d r1=%0d n=%0d want 2/0/1",
                     ri[6], ri[1], inflight);
        else pass_cnt++;
    endtask

    task automatic test_mispredict();
        do_reset();
        issue(3'd1, 1'b0);
        issue(3'd6, 1'b0);
        flush_idex  = 1'b1;
        flush_exmem = 1'b1;
        step();
        idle_inputs();
        total_cnt++;
        if (ri[1] !== 3'd0 || ri[6] !== 3'd0)
            $display("FAIL mispredict_codes got %0d/%0d want 0/0",
                     ri[1], ri[6]);
        else pass_cnt++;
        total_cnt++;
        if (inflight !== 2'd1 || empty !== 1'b0)
            $display("FAIL mispredict_status got n=%0d e=%b want 1/0",
                     inflight, empty);
        else pass_cnt++;
    endtask

    task automatic test_mid_reset();
        do_reset();
        issue(3'd1, 1'b0);
        issue(3'd2, 1'b0);
        issue(3'd3, 1'b0);
        total_cnt++;
        if (ri[3] !== 3'd2 || ri[2] !== 3'd3 || ri[1] !== 3'd0 ||
            inflight !== 2'd3)
            $display("FAIL full_pipe got %0d/%0d/%0d n=%0d want 2/3/0/3",
                     ri[3], ri[2], ri[1], inflight);
        else pass_cnt++;
        reset        = 1'b1;
        regwrite_cur = 1'b1;
        dest_id      = 3'd7;
        step();
        reset = 1'b0;
        idle_inputs();
        for (int r = 0; r < NREG; r++) begin
            total_cnt++;
            if (ri[r] !== 3'd0)
                $display("FAIL midreset_code[%0d] got %0d want 0", r, ri[r]);
            else pass_cnt++;
        end
        total_cnt++;
        if (empty !== 1'b1 || inflight !== 2'd0)
            $display("FAIL midreset_status e=%b n=%0d want 1/0",
                     empty, inflight);
        else pass_cnt++;
    endtask

    initial begin
        reset = 1'b1;
        idle_inputs();
        #1;
        test_reset();
        test_alu_write();
        test_load();
        test_back_to_back();
        test_stall();
        test_hold();
        test_mispredict();
        test_mid_reset();
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
